// File: rtl/coherent_dcache_if.sv
// CPU-side and coherence-bus signals of the coherent data cache.
interface coherent_dcache_if;
    // CPU request side
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic [31:0] dmemload;
    logic        dhit;
    // memory-control side
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        cctrans;
    logic        ccwait;
    logic [31:0] ccsnoopaddr;
    logic        ccinv;
    logic        ccwrite;

    // cache view
    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dmemload, dhit,
        output dREN, dWEN, daddr, dstore, cctrans, ccwrite,
        input  dload, dwait, ccwait, ccsnoopaddr, ccinv
    );

    // CPU + memory-control view
    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dmemload, dhit,
        input  dREN, dWEN, daddr, dstore, cctrans, ccwrite,
        output dload, dwait, ccwait, ccsnoopaddr, ccinv
    );
endinterface

// File: rtl/coherent_dcache.sv
// Direct-mapped, two-word-block, MSI-coherent write-back data cache.
module coherent_dcache #(
    parameter int unsigned CPUID = 0,
    parameter int unsigned SETS  = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    coherent_dcache_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 32 - 3 - IDX_W;

    typedef enum logic [2:0] {IDLE, WB1, WB2, LD1, LD2, SNP1, SNP2} state_t;

    state_t            state;
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [31:0]       data_q [SETS][2];

    // latched miss request and snoop context
    logic [TAG_W-1:0]  lat_tag;
    logic [IDX_W-1:0]  lat_idx;
    logic              lat_wr;
    logic [IDX_W-1:0]  snp_idx_q;
    logic              snp_inv_q;

    // registered bus outputs
    logic              dren_q;
    logic              dwen_q;
    logic              cctrans_q;
    logic [31:0]       daddr_q;
    logic [31:0]       dstore_q;

    // CPU address decode
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic              req_off;
    logic [TAG_W-1:0]  snp_tag;
    logic [IDX_W-1:0]  snp_idx;

    assign req_tag = bus.dmemaddr[31:3+IDX_W];
    assign req_idx = bus.dmemaddr[3+IDX_W-1:3];
    assign req_off = bus.dmemaddr[2];
    assign snp_tag = bus.ccsnoopaddr[31:3+IDX_W];
    assign snp_idx = bus.ccsnoopaddr[3+IDX_W-1:3];

    logic [31:0] unused_bits;
    assign unused_bits = {bus.dmemaddr[1:0], bus.ccsnoopaddr[2:0], 27'(CPUID)};

    // word address of word w of the block (tag, idx)
    function automatic logic [31:0] blk_addr(input logic [TAG_W-1:0] tag,
                                             input logic [IDX_W-1:0] idx,
                                             input logic w);
        return {tag, idx, w, 2'b00};
    endfunction

    logic line_match;
    logic rd_hit;
    logic wr_hit;
    logic cpu_req;
    logic cpu_go;
    logic snp_match;
    logic snp_hit_m;

    // hit detection for CPU and snoop lookups
    always_comb begin
        line_match = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        rd_hit     = bus.dmemREN && !bus.dmemWEN && line_match;
        wr_hit     = bus.dmemWEN && line_match && dirty_q[req_idx];
        cpu_req    = bus.dmemREN || bus.dmemWEN;
        cpu_go     = (state == IDLE) && !bus.ccwait;
        snp_match  = valid_q[snp_idx] && (tag_q[snp_idx] == snp_tag);
        snp_hit_m  = (state == IDLE) && bus.ccwait && snp_match && dirty_q[snp_idx];
    end

    // same-cycle CPU response and snoop-supply indication
    always_comb begin
        bus.dhit     = cpu_go && (rd_hit || wr_hit);
        bus.dmemload = (cpu_go && rd_hit) ? data_q[req_idx][req_off] : 32'd0;
        bus.ccwrite  = snp_hit_m;
    end

    assign bus.dREN    = dren_q;
    assign bus.dWEN    = dwen_q;
    assign bus.cctrans = cctrans_q;
    assign bus.daddr   = daddr_q;
    assign bus.dstore  = dstore_q;

    // controller: state, line array, latched context and registered bus outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            valid_q   <= '0;
            dirty_q   <= '0;
            tag_q     <= '{default: '0};
            data_q    <= '{default: '{default: '0}};
            lat_tag   <= '0;
            lat_idx   <= '0;
            lat_wr    <= 1'b0;
            snp_idx_q <= '0;
            snp_inv_q <= 1'b0;
            dren_q    <= 1'b0;
            dwen_q    <= 1'b0;
            cctrans_q <= 1'b0;
            daddr_q   <= '0;
            dstore_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ccwait) begin
                        if (snp_hit_m) begin
                            state     <= SNP1;
                            snp_idx_q <= snp_idx;
                            snp_inv_q <= bus.ccinv;
                            daddr_q   <= blk_addr(snp_tag, snp_idx, 1'b0);
                            dstore_q  <= data_q[snp_idx][0];
                        end else if (snp_match && bus.ccinv) begin
                            valid_q[snp_idx] <= 1'b0;
                        end
                    end else if (wr_hit) begin
                        data_q[req_idx][req_off] <= bus.dmemstore;
                    end else if (cpu_req && !rd_hit) begin
                        lat_tag <= req_tag;
                        lat_idx <= req_idx;
                        lat_wr  <= bus.dmemWEN;
                        if (valid_q[req_idx] && dirty_q[req_idx] &&
                            (tag_q[req_idx] != req_tag)) begin
                            state    <= WB1;
                            dwen_q   <= 1'b1;
                            daddr_q  <= blk_addr(tag_q[req_idx], req_idx, 1'b0);
                            dstore_q <= data_q[req_idx][0];
                        end else begin
                            state     <= LD1;
                            dren_q    <= 1'b1;
                            cctrans_q <= bus.dmemWEN;
                            daddr_q   <= blk_addr(req_tag, req_idx, 1'b0);
                        end
                    end
                end
                WB1: begin
                    if (!bus.dwait) begin
                        state    <= WB2;
                        daddr_q  <= blk_addr(tag_q[lat_idx], lat_idx, 1'b1);
                        dstore_q <= data_q[lat_idx][1];
                    end
                end
                WB2: begin
                    if (!bus.dwait) begin
                        state     <= LD1;
                        dwen_q    <= 1'b0;
                        dren_q    <= 1'b1;
                        cctrans_q <= lat_wr;
                        daddr_q   <= blk_addr(lat_tag, lat_idx, 1'b0);
                        dstore_q  <= '0;
                    end
                end
                LD1: begin
                    if (!bus.dwait) begin
                        state                <= LD2;
                        data_q[lat_idx][0]   <= bus.dload;
                        valid_q[lat_idx]     <= 1'b0;
                        daddr_q              <= blk_addr(lat_tag, lat_idx, 1'b1);
                    end
                end
                LD2: begin
                    if (!bus.dwait) begin
                        state              <= IDLE;
                        data_q[lat_idx][1] <= bus.dload;
                        tag_q[lat_idx]     <= lat_tag;
                        valid_q[lat_idx]   <= 1'b1;
                        dirty_q[lat_idx]   <= lat_wr;
                        dren_q             <= 1'b0;
                        cctrans_q          <= 1'b0;
                        daddr_q            <= '0;
                    end
                end
                SNP1: begin
                    if (!bus.dwait) begin
                        state    <= SNP2;
                        daddr_q  <= blk_addr(tag_q[snp_idx_q], snp_idx_q, 1'b1);
                        dstore_q <= data_q[snp_idx_q][1];
                    end
                end
                SNP2: begin
                    if (!bus.dwait) begin
                        state              <= IDLE;
                        dirty_q[snp_idx_q] <= 1'b0;
                        valid_q[snp_idx_q] <= !snp_inv_q;
                        daddr_q            <= '0;
                        dstore_q           <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coherent_dcache.sv
// Directed self-checking bench for coherent_dcache.
module tb_coherent_dcache;
    logic clk;
    logic nrst;
    int   n_assert;
    int   n_fail;

    coherent_dcache_if bus();

    coherent_dcache #(.CPUID(0), .SETS(8)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d);
        bus.dmemREN   = ren;
        bus.dmemWEN   = wen;
        bus.dmemaddr  = a;
        bus.dmemstore = d;
    endtask

    // entered at a falling edge with the cache in LD1; leaves at the falling edge back in IDLE
    task automatic ld_pair(input string tag, input logic [31:0] base, input logic [31:0] w0,
                           input logic [31:0] w1, input logic trans);
        #1;
        chk({tag, "_ld1_dren"},    32'(bus.dREN), 32'd1);
        chk({tag, "_ld1_dwen"},    32'(bus.dWEN), 32'd0);
        chk({tag, "_ld1_daddr"},   bus.daddr, base);
        chk({tag, "_ld1_cctrans"}, 32'(bus.cctrans), 32'(trans));
        chk({tag, "_ld1_dhit"},    32'(bus.dhit), 32'd0);
        bus.dwait = 1'b0;
        bus.dload = w0;
        @(negedge clk);
        #1;
        chk({tag, "_ld2_daddr"},   bus.daddr, base + 32'd4);
        chk({tag, "_ld2_cctrans"}, 32'(bus.cctrans), 32'(trans));
        bus.dload = w1;
        @(negedge clk);
        bus.dwait = 1'b1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        nrst = 1'b0;
        cpu(1'b0, 1'b0, 32'd0, 32'd0);
        bus.dload       = '0;
        bus.dwait       = 1'b1;
        bus.ccwait      = 1'b0;
        bus.ccsnoopaddr = '0;
        bus.ccinv       = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dhit",     32'(bus.dhit), 32'd0);
        chk("rst_dren",     32'(bus.dREN), 32'd0);
        chk("rst_dwen",     32'(bus.dWEN), 32'd0);
        chk("rst_cctrans",  32'(bus.cctrans), 32'd0);
        chk("rst_ccwrite",  32'(bus.ccwrite), 32'd0);
        chk("rst_daddr",    bus.daddr, 32'd0);
        chk("rst_dstore",   bus.dstore, 32'd0);
        chk("rst_dmemload", bus.dmemload, 32'd0);
        nrst = 1'b1;

        // cold read miss, bus stall held, fill to S
        @(negedge clk);
        cpu(1'b1, 1'b0, 32'h40, 32'd0);
        #1 chk("t1_miss_dhit", 32'(bus.dhit), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t1_hold_daddr", bus.daddr, 32'h40);
        chk("t1_hold_dren",  32'(bus.dREN), 32'd1);
        ld_pair("t1", 32'h40, 32'hA, 32'hB, 1'b0);
        #1;
        chk("t1_hit_dhit", 32'(bus.dhit), 32'd1);
        chk("t1_hit_load", bus.dmemload, 32'hA);
        chk("t1_idle_dren", 32'(bus.dREN), 32'd0);
        cpu(1'b1, 1'b0, 32'h44, 32'd0);
        #1 chk("t1_hit_w1", bus.dmemload, 32'hB);

        // write to S line: read-exclusive refill, then write hit on M
        @(negedge clk);
        cpu(1'b0, 1'b1, 32'h44, 32'h55);
        #1 chk("t2_wr_s_dhit", 32'(bus.dhit), 32'd0);
        @(negedge clk);
        ld_pair("t2", 32'h40, 32'hA, 32'hB, 1'b1);
        #1 chk("t2_wr_hit_dhit", 32'(bus.dhit), 32'd1);
        @(negedge clk);
        cpu(1'b1, 1'b0, 32'h44, 32'd0);
        #1;
        chk("t2_rd_dhit", 32'(bus.dhit), 32'd1);
        chk("t2_rd_load", bus.dmemload, 32'h55);

        // snoop hit on M without invalidate: supply both words, downgrade to S
        @(negedge clk);
        cpu(1'b1, 1'b0, 32'h40, 32'd0);
        bus.ccwait      = 1'b1;
        bus.ccsnoopaddr = 32'h40;
        bus.ccinv       = 1'b0;
        #1;
        chk("t3_ccwrite",  32'(bus.ccwrite), 32'd1);
        chk("t3_cpu_ign",  32'(bus.dhit), 32'd0);
        chk("t3_load_ign", bus.dmemload, 32'd0);
        @(negedge clk);
        bus.ccwait = 1'b0;
        cpu(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("t3_snp1_daddr",  bus.daddr, 32'h40);
        chk("t3_snp1_dstore", bus.dstore, 32'hA);
        chk("t3_snp1_dren",   32'(bus.dREN), 32'd0);
        chk("t3_snp1_dwen",   32'(bus.dWEN), 32'd0);
        chk("t3_snp1_ccw",    32'(bus.ccwrite), 32'd0);
        bus.dwait = 1'b0;
        @(negedge clk);
        #1;
        chk("t3_snp2_daddr",  bus.daddr, 32'h44);
        chk("t3_snp2_dstore", bus.dstore, 32'h55);
        @(negedge clk);
        bus.dwait = 1'b1;
        cpu(1'b1, 1'b0, 32'h44, 32'd0);
        #1;
        chk("t3_idle_daddr", bus.daddr, 32'd0);
        chk("t3_after_hit",  32'(bus.dhit), 32'd1);
        chk("t3_after_load", bus.dmemload, 32'h55);

        // snoop invalidate on S line: no supply, next read misses
        @(negedge clk);
        cpu(1'b0, 1'b0, 32'd0, 32'd0);
        bus.ccwait = 1'b1;
        bus.ccinv  = 1'b1;
        #1 chk("t4_ccwrite_s", 32'(bus.ccwrite), 32'd0);
        @(negedge clk);
        bus.ccwait = 1'b0;
        bus.ccinv  = 1'b0;
        cpu(1'b1, 1'b0, 32'h40, 32'd0);
        #1 chk("t4_inv_miss", 32'(bus.dhit), 32'd0);
        @(negedge clk);
        ld_pair("t4", 32'h40, 32'h11, 32'h22, 1'b0);
        #1 chk("t4_refill_load", bus.dmemload, 32'h11);

        // dirty victim eviction: write-back old words, then fill new tag
        @(negedge clk);
        cpu(1'b0, 1'b1, 32'h40, 32'h33);
        @(negedge clk);
        ld_pair("t5a", 32'h40, 32'h11, 32'h22, 1'b1);
        #1 chk("t5_wr_hit", 32'(bus.dhit), 32'd1);
        @(negedge clk);
        cpu(1'b1, 1'b0, 32'h80, 32'd0);
        #1 chk("t5_conflict_miss", 32'(bus.dhit), 32'd0);
        @(negedge clk);
        #1;
        chk("t5_wb1_dwen",   32'(bus.dWEN), 32'd1);
        chk("t5_wb1_dren",   32'(bus.dREN), 32'd0);
        chk("t5_wb1_daddr",  bus.daddr, 32'h40);
        chk("t5_wb1_dstore", bus.dstore, 32'h33);
        bus.dwait = 1'b0;
        @(negedge clk);
        #1;
        chk("t5_wb2_daddr",  bus.daddr, 32'h44);
        chk("t5_wb2_dstore", bus.dstore, 32'h22);
        chk("t5_wb2_dwen",   32'(bus.dWEN), 32'd1);
        @(negedge clk);
        #1 chk("t5_ld_dstore", bus.dstore, 32'd0);
        ld_pair("t5b", 32'h80, 32'h77, 32'h88, 1'b0);
        #1 chk("t5_new_load", bus.dmemload, 32'h77);
        @(negedge clk);
        cpu(1'b0, 1'b0, 32'd0, 32'd0);
        bus.ccwait      = 1'b1;
        bus.ccsnoopaddr = 32'h100;
        bus.ccinv       = 1'b1;
        #1 chk("t5_snoop_miss", 32'(bus.ccwrite), 32'd0);
        @(negedge clk);
        bus.ccwait = 1'b0;
        bus.ccinv  = 1'b0;
        cpu(1'b1, 1'b0, 32'h84, 32'd0);
        #1;
        chk("t5_kept_hit",  32'(bus.dhit), 32'd1);
        chk("t5_kept_load", bus.dmemload, 32'h88);

        // reset during LD2 with the bus stalled
        @(negedge clk);
        cpu(1'b1, 1'b0, 32'h48, 32'd0);
        @(negedge clk);
        bus.dwait = 1'b0;
        bus.dload = 32'h5;
        @(negedge clk);
        bus.dwait = 1'b1;
        #1 chk("t6_ld2_daddr", bus.daddr, 32'h4C);
        nrst = 1'b0;
        #1;
        chk("t6_rst_dren",    32'(bus.dREN), 32'd0);
        chk("t6_rst_daddr",   bus.daddr, 32'd0);
        chk("t6_rst_cctrans", 32'(bus.cctrans), 32'd0);
        chk("t6_rst_dhit",    32'(bus.dhit), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        cpu(1'b1, 1'b0, 32'h84, 32'd0);
        #1 chk("t6_post_miss", 32'(bus.dhit), 32'd0);
        @(negedge clk);
        #1;
        chk("t6_post_dren",  32'(bus.dREN), 32'd1);
        chk("t6_post_daddr", bus.daddr, 32'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
